// File: rtl/tb_uart_pkg.sv
// Shared types and frame constants for the tb_uart 8N1 UART.
package tb_uart_pkg;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_WAIT
    } rx_state_t;

    localparam int         DATA_W      = 8;
    localparam logic [3:0] DATA_BITS   = 4'd8;
    localparam logic [3:0] FRAME_BITS  = 4'd10;
    localparam logic       IDLE_LEVEL  = 1'b1;
    localparam int         SYNC_STAGES = 2;

endpackage

// File: rtl/tb_uart_rx.sv
// 8N1 receiver: synchronizes ser_rx, validates the start bit at its centre,
// then samples data and stop bits once per bit period.
module tb_uart_rx
    import tb_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4167
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              ser_rx,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              rx_frame_err
);

    localparam logic [15:0] CNT_LAST = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] CNT_HALF = 16'(CLKS_PER_BIT / 2 - 1);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   rx_line;
    logic                   prev_reg;

    rx_state_t         state_reg, state_next;
    logic [15:0]       cnt_reg, cnt_next;
    logic [3:0]        bit_reg, bit_next;
    logic [DATA_W-1:0] shift_reg, shift_next;
    logic [DATA_W-1:0] data_reg, data_next;
    logic              valid_reg, valid_next;
    logic              err_reg, err_next;

    assign rx_line = sync_reg[SYNC_STAGES-1];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_reg  <= {SYNC_STAGES{IDLE_LEVEL}};
            prev_reg  <= IDLE_LEVEL;
            state_reg <= RX_IDLE;
            cnt_reg   <= '0;
            bit_reg   <= '0;
            shift_reg <= '0;
            data_reg  <= '0;
            valid_reg <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            sync_reg  <= {sync_reg[SYNC_STAGES-2:0], ser_rx};
            prev_reg  <= rx_line;
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            bit_reg   <= bit_next;
            shift_reg <= shift_next;
            data_reg  <= data_next;
            valid_reg <= valid_next;
            err_reg   <= err_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg + 16'd1;
        bit_next   = bit_reg;
        shift_next = shift_reg;
        data_next  = data_reg;
        valid_next = 1'b0;
        err_next   = 1'b0;
        case (state_reg)
            RX_IDLE: begin
                cnt_next = '0;
                if (prev_reg && !rx_line) begin
                    state_next = RX_START;
                    bit_next   = '0;
                end
            end
            RX_START: begin
                // Half a bit in: a high line means the fall was only a glitch.
                if (cnt_reg == CNT_HALF) begin
                    cnt_next   = '0;
                    state_next = rx_line ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (cnt_reg == CNT_LAST) begin
                    cnt_next   = '0;
                    shift_next = {rx_line, shift_reg[DATA_W-1:1]};
                    if (bit_reg == DATA_BITS - 4'd1)
                        state_next = RX_STOP;
                    else
                        bit_next = bit_reg + 4'd1;
                end
            end
            RX_STOP: begin
                if (cnt_reg == CNT_LAST) begin
                    cnt_next = '0;
                    if (rx_line) begin
                        valid_next = 1'b1;
                        data_next  = shift_reg;
                        state_next = RX_IDLE;
                    end else begin
                        err_next   = 1'b1;
                        state_next = RX_WAIT;
                    end
                end
            end
            RX_WAIT: begin
                cnt_next = '0;
                if (rx_line)
                    state_next = RX_IDLE;
            end
            default: begin
                cnt_next   = '0;
                state_next = RX_IDLE;
            end
        endcase
    end

    assign rx_data      = data_reg;
    assign rx_valid     = valid_reg;
    assign rx_frame_err = err_reg;

endmodule

// File: rtl/tb_uart.sv
// 8N1 UART: transmitter lives here; receiver is built only when TB_UART_RX_EN
// is defined, otherwise the rx outputs are tied low and ser_rx is ignored.
module tb_uart
    import tb_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4167
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              tx_start,
    input  logic [DATA_W-1:0] tx_data,
    output logic              ser_tx,
    output logic              tx_busy,
    output logic              tx_clear_req,
    input  logic              ser_rx,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              rx_frame_err
);

    localparam logic [15:0] CNT_LAST = 16'(CLKS_PER_BIT - 1);

    tx_state_t         state_reg, state_next;
    logic [15:0]       cnt_reg, cnt_next;
    logic [3:0]        pos_reg, pos_next;
    logic [DATA_W-1:0] data_reg, data_next;
    logic              ser_reg, ser_next;
    logic              start_prev_reg;
    logic              start_edge;
    logic              cnt_last;

    // Edge detector resets to "previously high" so a held tx_start cannot fire.
    assign start_edge = tx_start & ~start_prev_reg;
    assign cnt_last   = (cnt_reg == CNT_LAST);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg      <= TX_IDLE;
            cnt_reg        <= '0;
            pos_reg        <= '0;
            data_reg       <= '0;
            ser_reg        <= IDLE_LEVEL;
            start_prev_reg <= 1'b1;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            pos_reg        <= pos_next;
            data_reg       <= data_next;
            ser_reg        <= ser_next;
            start_prev_reg <= tx_start;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg + 16'd1;
        pos_next   = pos_reg;
        data_next  = data_reg;
        ser_next   = ser_reg;
        case (state_reg)
            TX_IDLE: begin
                cnt_next = '0;
                if (start_edge) begin
                    state_next = TX_START;
                    pos_next   = '0;
                    data_next  = tx_data;
                    ser_next   = 1'b0;
                end
            end
            TX_START: begin
                if (cnt_last) begin
                    cnt_next   = '0;
                    pos_next   = pos_reg + 4'd1;
                    state_next = TX_DATA;
                    ser_next   = data_reg[0];
                    data_next  = data_reg >> 1;
                end
            end
            TX_DATA: begin
                // pos_reg tracks the bit slot within the frame; slot 8 is the last data bit.
                if (cnt_last) begin
                    cnt_next = '0;
                    pos_next = pos_reg + 4'd1;
                    if (pos_reg == FRAME_BITS - 4'd2) begin
                        state_next = TX_STOP;
                        ser_next   = IDLE_LEVEL;
                    end else begin
                        ser_next  = data_reg[0];
                        data_next = data_reg >> 1;
                    end
                end
            end
            TX_STOP: begin
                if (cnt_last) begin
                    cnt_next   = '0;
                    pos_next   = '0;
                    state_next = TX_IDLE;
                    ser_next   = IDLE_LEVEL;
                end
            end
            default: begin
                cnt_next   = '0;
                state_next = TX_IDLE;
                ser_next   = IDLE_LEVEL;
            end
        endcase
    end

    assign ser_tx       = ser_reg;
    assign tx_busy      = (state_reg != TX_IDLE);
    assign tx_clear_req = (state_reg == TX_STOP) && cnt_last;

`ifdef TB_UART_RX_EN
    tb_uart_rx #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_rx (
        .clock        (clock),
        .reset        (reset),
        .ser_rx       (ser_rx),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_frame_err (rx_frame_err)
    );
`else
    logic unused_ser_rx;
    assign unused_ser_rx = ser_rx;
    assign rx_data       = '0;
    assign rx_valid      = 1'b0;
    assign rx_frame_err  = 1'b0;
`endif

endmodule

// File: tb/tb_tb_uart.sv
// Directed self-checking bench for tb_uart at CLKS_PER_BIT=16; receiver checks
// follow whether TB_UART_RX_EN is defined.
module tb_tb_uart;

    localparam int CPB = 16;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       tx_start = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       ser_rx = 1'b1;
    logic       ser_tx;
    logic       tx_busy;
    logic       tx_clear_req;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_frame_err;

    int n_asserts = 0;
    int n_fail    = 0;

    tb_uart #(.CLKS_PER_BIT(CPB)) dut (
        .clock        (clock),
        .reset        (reset),
        .tx_start     (tx_start),
        .tx_data      (tx_data),
        .ser_tx       (ser_tx),
        .tx_busy      (tx_busy),
        .tx_clear_req (tx_clear_req),
        .ser_rx       (ser_rx),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_frame_err (rx_frame_err)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Caller raises tx_start just before; k=1 is the first cycle of the start bit.
    task automatic run_tx(input string tag, input logic [9:0] exp_frame, input int ncyc,
                          input bit disturb);
        int busy_cnt = 0;
        int clr_cnt  = 0;
        for (int k = 1; k <= ncyc; k++) begin
            @(negedge clock);
            if (k == 1) begin
                check({tag, "_first_ser"}, 32'(ser_tx), 32'd0);
                check({tag, "_first_busy"}, 32'(tx_busy), 32'd1);
            end
            if (k <= 10 * CPB && (k % CPB) == CPB / 2)
                check($sformatf("%s_bit%0d", tag, (k - CPB / 2) / CPB), 32'(ser_tx),
                      32'(exp_frame[(k - CPB / 2) / CPB]));
            if (tx_busy) busy_cnt++;
            if (tx_clear_req) begin
                clr_cnt++;
                check({tag, "_clr_pos"}, 32'(k), 32'(10 * CPB));
            end
            if (disturb) begin
                if (k == 40) tx_data = ~tx_data;
                if (k == 60) tx_start = 1'b0;
                if (k == 61) tx_start = 1'b1;
            end
        end
        check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(10 * CPB));
        check({tag, "_clr_count"}, 32'(clr_cnt), 32'd1);
        check({tag, "_end_ser"}, 32'(ser_tx), 32'd1);
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop, output int nv, output int ne);
        logic bv;
        nv = 0;
        ne = 0;
        for (int i = 0; i < 10; i++) begin
            if (i == 0) bv = 1'b0;
            else if (i == 9) bv = stop;
            else bv = b[i-1];
            for (int c = 0; c < CPB; c++) begin
                @(negedge clock);
                if (rx_valid) nv++;
                if (rx_frame_err) ne++;
                if (c == 0) ser_rx = bv;
            end
        end
        @(negedge clock);
        ser_rx = 1'b1;
        for (int c = 0; c < 2 * CPB; c++) begin
            @(negedge clock);
            if (rx_valid) nv++;
            if (rx_frame_err) ne++;
        end
    endtask

    initial begin
        int nv;
        int ne;
        int busy_cnt;

        // Reset state
        repeat (3) @(negedge clock);
        check("rst_ser_tx", 32'(ser_tx), 32'd1);
        check("rst_busy", 32'(tx_busy), 32'd0);
        check("rst_clr", 32'(tx_clear_req), 32'd0);
        check("rst_rx_data", 32'(rx_data), 32'd0);
        check("rst_rx_valid", 32'(rx_valid), 32'd0);
        check("rst_rx_err", 32'(rx_frame_err), 32'd0);
        reset = 1'b0;
        repeat (3) @(negedge clock);
        check("idle_busy", 32'(tx_busy), 32'd0);

        // 0x3D with a tx_data change and a tx_start re-edge mid-frame
        $display("tx 0x3D with mid-frame disturbance");
        tx_data  = 8'h3D;
        tx_start = 1'b1;
        run_tx("tx3d", 10'b1001111010, 170, 1'b1);

        // 0x0F with tx_start held high for 300 cycles
        $display("tx 0x0F with tx_start held");
        tx_start = 1'b0;
        repeat (3) @(negedge clock);
        tx_data  = 8'h0F;
        tx_start = 1'b1;
        run_tx("tx0f", 10'b1000011110, 300, 1'b0);

        // Reset 50 cycles into a frame, then a clean frame
        $display("tx reset mid-frame then 0x81");
        tx_start = 1'b0;
        repeat (3) @(negedge clock);
        tx_data  = 8'h55;
        tx_start = 1'b1;
        repeat (50) @(negedge clock);
        check("pre_rst_busy", 32'(tx_busy), 32'd1);
        reset = 1'b1;
        #1;
        check("abort_ser_tx", 32'(ser_tx), 32'd1);
        check("abort_busy", 32'(tx_busy), 32'd0);
        check("abort_clr", 32'(tx_clear_req), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        busy_cnt = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clock);
            if (tx_busy || tx_clear_req) busy_cnt++;
        end
        check("post_rst_quiet", 32'(busy_cnt), 32'd0);
        tx_start = 1'b0;
        @(negedge clock);
        tx_data  = 8'h81;
        tx_start = 1'b1;
        run_tx("tx81", 10'b1100000010, 170, 1'b0);
        tx_start = 1'b0;

`ifdef TB_UART_RX_EN
        $display("rx 0xA5 good frame");
        send_rx(8'hA5, 1'b1, nv, ne);
        check("rxa5_valid", 32'(nv), 32'd1);
        check("rxa5_err", 32'(ne), 32'd0);
        check("rxa5_data", 32'(rx_data), 32'hA5);

        $display("rx 0x3C with stop bit low");
        send_rx(8'h3C, 1'b0, nv, ne);
        check("rxerr_valid", 32'(nv), 32'd0);
        check("rxerr_err", 32'(ne), 32'd1);
        check("rxerr_data", 32'(rx_data), 32'hA5);

        $display("rx 4-cycle glitch");
        @(negedge clock);
        ser_rx = 1'b0;
        repeat (4) @(negedge clock);
        ser_rx = 1'b1;
        nv = 0;
        ne = 0;
        for (int c = 0; c < 3 * CPB; c++) begin
            @(negedge clock);
            if (rx_valid) nv++;
            if (rx_frame_err) ne++;
        end
        check("glitch_valid", 32'(nv), 32'd0);
        check("glitch_err", 32'(ne), 32'd0);

        $display("rx 0x5A concurrent with tx 0x3D");
        tx_data  = 8'h3D;
        tx_start = 1'b1;
        fork
            run_tx("txpar", 10'b1001111010, 170, 1'b0);
            send_rx(8'h5A, 1'b1, nv, ne);
        join
        check("rx5a_valid", 32'(nv), 32'd1);
        check("rx5a_err", 32'(ne), 32'd0);
        check("rx5a_data", 32'(rx_data), 32'h5A);
`else
        $display("rx disabled: frame on ser_rx must be ignored");
        send_rx(8'hA5, 1'b1, nv, ne);
        check("rxoff_valid", 32'(nv), 32'd0);
        check("rxoff_err", 32'(ne), 32'd0);
        check("rxoff_data", 32'(rx_data), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
